// File: rtl/rv32_branch_pkg.sv
// Shared encodings for branch resolution: funct3 codes, BHT counter states, resolve FSM states.
package rv32_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, async IF read port, sync EX update port.
module branch_bht
    import rv32_branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    // Read sees the stored value, so a same-cycle update is not forwarded.
    assign o_rd_ctr = ctr_q[i_rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (i_wr_en) begin
            if (i_wr_taken) begin
                if (ctr_q[i_wr_idx] != ST) ctr_d[i_wr_idx] = ctr_q[i_wr_idx] + 2'd1;
            end else begin
                if (ctr_q[i_wr_idx] != SNT) ctr_d[i_wr_idx] = ctr_q[i_wr_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: taken decode, mispredict redirect/flush, BHT ownership.
// Optional BRANCH_STATS_EN adds saturating branch and redirect counters.
//
// state  | meaning
// RUN    | EX instruction is on the correct path and may resolve
// SHADOW | cycle after a redirect; wrong-path EX instruction is ignored
module branch_resolve
    import rv32_branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_if_pc,
    output logic        o_if_pred_taken,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic        i_pred_taken,
    input  logic [31:0] i_target,
    output logic        o_brUn,
    output logic        o_br_comp,
    input  logic        brEq,
    input  logic        brLT,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    fsm_state_e  state_q, state_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        resolve, taken, legal, br_res, mispred;
    logic [1:0]  if_ctr;

    assign resolve = i_valid && (state_q == RUN);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (i_funct3)
            F3_BEQ:          taken = brEq;
            F3_BNE:          taken = ~brEq;
            F3_BLT, F3_BLTU: taken = brLT;
            F3_BGE, F3_BGEU: taken = ~brLT;
            default:         legal = 1'b0;
        endcase
    end

    // Jumps take priority over the branch flag when decode sets several.
    assign br_res  = resolve && !i_is_jalr && !i_is_jal && i_is_branch && legal;
    assign mispred = br_res && (taken != i_pred_taken);

    always_comb begin
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (resolve && i_is_jalr) begin
            redirect_d    = 1'b1;
            redirect_pc_d = {i_target[31:1], 1'b0};
        end else if (resolve && i_is_jal) begin
            redirect_d    = 1'b1;
            redirect_pc_d = i_target;
        end else if (mispred) begin
            redirect_d    = 1'b1;
            redirect_pc_d = taken ? i_target : i_pc + 32'd4;
        end
        state_d = redirect_d ? SHADOW : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_brUn        = i_funct3[1];
    assign o_br_comp     = i_valid && i_is_branch && (state_q == RUN);
    assign o_redirect    = redirect_q;
    assign o_flush       = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_if_pred_taken = if_ctr[1];

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (i_if_pc[IDX_W+1:2]),
        .o_rd_ctr   (if_ctr),
        .i_wr_en    (br_res),
        .i_wr_idx   (i_pc[IDX_W+1:2]),
        .i_wr_taken (taken)
    );

    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (br_res && br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
        if (redirect_d && mispred_count_q != 32'hFFFF_FFFF) mispred_count_d = mispred_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign o_br_count      = br_count_q;
    assign o_mispred_count = mispred_count_q;
`endif

endmodule
